univ_shift_register: RTL

- Parametrised universal shift register: hold, shift right, shift left or parallel load, with clock enable and serial ports at both ends.
- Adds an automatic burst controller: `start` loads a word and shifts it out over exactly N enabled cycles, then pulses `done`.
- Serves as the common serializer/deserializer core for UART/SPI-style blocks in the sequential workshop modules.

---
 rtl/univ_shift_register_pkg.sv | 29 ++
 rtl/univ_shift_register_bit_counter.sv | 41 ++++
 rtl/univ_shift_register.sv | 118 +++++++++++
 3 files changed

// File: rtl/univ_shift_register_pkg.sv
// ============================================================================
// Module      : univ_shift_register_pkg
// Description : Shared constants for the universal shift register: manual
//               mode codes, burst FSM state encodings, burst direction codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package univ_shift_register_pkg;

  // Manual operation codes applied while the burst FSM is idle
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Burst direction, latched on the start edge
  localparam logic DIR_R = 1'b0;  // LSB first on sh_out_r
  localparam logic DIR_L = 1'b1;  // MSB first on sh_out_l

  // Burst controller states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage : univ_shift_register_pkg

`default_nettype wire

// File: rtl/univ_shift_register_bit_counter.sv
// ============================================================================
// Module      : shreg_bit_counter
// Description : Loadable down-counter with clock enable and terminal-count
//               flag (count == 1). Tracks the remaining shifts of a burst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shreg_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,       // asynchronous, active-low
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          tc
);

  logic [CW-1:0] count;

  // Load takes priority over decrement; counting saturates at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_val;
      end else if (dec && (count != '0)) begin
        count <= count - CW'(1);
      end
    end
  end

  // Terminal count: the edge that sees this flag performs the final shift
  assign tc = (count == CW'(1));

endmodule : shreg_bit_counter

`default_nettype wire

// File: rtl/univ_shift_register.sv
// ============================================================================
// Module      : univ_shift_register
// Description : Parametrised universal shift register (hold / shift right /
//               shift left / parallel load) with clock enable, serial ports at
//               both ends and an automatic N-shift burst controller.
//               Optional macro SHREG_ROTATE_EN adds the 'rot' input, which
//               recirculates the shifted-out bit instead of the serial input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_register
  import univ_shift_register_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,       // asynchronous, active-low
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         start,
  input  logic         dir,
  input  logic [N-1:0] d,
  input  logic         sh_in_r,
  input  logic         sh_in_l,
`ifdef SHREG_ROTATE_EN
  input  logic         rot,
`endif
  output logic [N-1:0] q,
  output logic         sh_out_r,
  output logic         sh_out_l,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  state_t       state;
  logic         dir_lat;
  logic         rot_eff;
  logic         tc;
  logic         cnt_load;
  logic         cnt_dec;
  logic [N-1:0] shr_val;
  logic [N-1:0] shl_val;

`ifdef SHREG_ROTATE_EN
  assign rot_eff = rot;
`else
  assign rot_eff = 1'b0;
`endif

  // Next-value candidates for one-position shifts; rotation feeds back the
  // bit that leaves the opposite end
  assign shr_val = {(rot_eff ? q[0]   : sh_in_r), q[N-1:1]};
  assign shl_val = {q[N-2:0], (rot_eff ? q[N-1] : sh_in_l)};

  assign sh_out_r = q[0];
  assign sh_out_l = q[N-1];

  assign cnt_load = (state == ST_IDLE) && start;
  assign cnt_dec  = (state == ST_SHIFT);

  shreg_bit_counter #(
    .CW (CW)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (cnt_load),
    .load_val (CW'(N)),
    .dec      (cnt_dec),
    .tc       (tc)
  );

  // Burst FSM and datapath: start preempts manual mode in IDLE, manual
  // inputs are ignored while a burst is shifting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      q       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dir_lat <= DIR_R;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            q       <= d;
            dir_lat <= dir;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end else begin
            case (mode)
              MODE_SHR:  q <= shr_val;
              MODE_SHL:  q <= shl_val;
              MODE_LOAD: q <= d;
              default:   q <= q;
            endcase
          end
        end
        ST_SHIFT: begin
          q <= (dir_lat == DIR_L) ? shl_val : shr_val;
          if (tc) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : univ_shift_register

`default_nettype wire
